// File: rtl/program_loader.sv
// Byte-stream program loader: assembles {instruction, data_var} records and writes them to program RAM.
// Optional per-record XOR checksum byte enabled by defining CHECKSUM_EN.
module program_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 9,
    parameter int DATA_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  word_count,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               write_en,
    output logic [ADDR_W-1:0]  write_address,
    output logic [INSTR_W-1:0] instruction,
    output logic [DATA_W-1:0]  data_var,
    output logic               busy,
    output logic               done,
    output logic               error
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // B0    | expect instr[7:0]
    // B1    | expect {reserved, instr[8]}
    // B2    | expect data[15:8]
    // B3    | expect data[7:0]
    // CHK   | expect XOR checksum byte (CHECKSUM_EN builds only)
    // WRITE | one-cycle write strobe, then next record or DONE
    // DONE  | load finished (or aborted); start begins a new load
    typedef enum logic [2:0] {
        S_IDLE, S_B0, S_B1, S_B2, S_B3, S_CHK, S_WRITE, S_DONE
    } state_t;

    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          ilo_q, ilo_d;
    logic                ihi_q, ihi_d;
    logic [7:0]          dhi_q, dhi_d;
    logic                arm_q;
    logic                xfer;
`ifdef CHECKSUM_EN
    logic [7:0]          dlo_q, dlo_d;
    logic [7:0]          chk_q, chk_d;
    logic                error_q, error_d;
`endif

    assign byte_ready    = (state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2) ||
                           (state_q == S_B3) || (state_q == S_CHK);
    assign xfer          = byte_valid && byte_ready;
    assign write_en      = (state_q == S_WRITE);
    assign busy          = byte_ready || (state_q == S_WRITE);
    assign done          = (state_q == S_DONE);
    assign write_address = waddr_q;
    assign instruction   = instr_q;
    assign data_var      = data_q;
`ifdef CHECKSUM_EN
    assign error         = error_q;
`else
    assign error         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        instr_d = instr_q;
        data_d  = data_q;
        ilo_d   = ilo_q;
        ihi_d   = ihi_q;
        dhi_d   = dhi_q;
`ifdef CHECKSUM_EN
        dlo_d   = dlo_q;
        chk_d   = chk_q;
        error_d = error_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                // arm_q blocks a start seen on the first edge after reset release
                if (start && arm_q) begin
                    count_d = (word_count == '0) ? CNT_FULL : {1'b0, word_count};
                    addr_d  = '0;
                    state_d = S_B0;
`ifdef CHECKSUM_EN
                    error_d = 1'b0;
`endif
                end
            end
            S_B0: if (xfer) begin
                ilo_d   = byte_in;
                state_d = S_B1;
`ifdef CHECKSUM_EN
                chk_d   = byte_in;
`endif
            end
            S_B1: if (xfer) begin
                ihi_d   = byte_in[0];
                state_d = S_B2;
`ifdef CHECKSUM_EN
                chk_d   = chk_q ^ byte_in;
`endif
            end
            S_B2: if (xfer) begin
                dhi_d   = byte_in;
                state_d = S_B3;
`ifdef CHECKSUM_EN
                chk_d   = chk_q ^ byte_in;
`endif
            end
            S_B3: if (xfer) begin
`ifdef CHECKSUM_EN
                dlo_d   = byte_in;
                chk_d   = chk_q ^ byte_in;
                state_d = S_CHK;
`else
                instr_d = {ihi_q, ilo_q};
                data_d  = {dhi_q, byte_in};
                waddr_d = addr_q;
                state_d = S_WRITE;
`endif
            end
            S_CHK: begin
`ifdef CHECKSUM_EN
                if (xfer) begin
                    if (byte_in == chk_q) begin
                        instr_d = {ihi_q, ilo_q};
                        data_d  = {dhi_q, dlo_q};
                        waddr_d = addr_q;
                        state_d = S_WRITE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;
                count_d = count_q - 1'b1;
                state_d = (count_q == CNT_ONE) ? S_DONE : S_B0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            waddr_q <= '0;
            instr_q <= '0;
            data_q  <= '0;
            ilo_q   <= '0;
            ihi_q   <= 1'b0;
            dhi_q   <= '0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            instr_q <= instr_d;
            data_q  <= data_d;
            ilo_q   <= ilo_d;
            ihi_q   <= ihi_d;
            dhi_q   <= dhi_d;
            arm_q   <= 1'b1;
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dlo_q   <= '0;
            chk_q   <= '0;
            error_q <= 1'b0;
        end else begin
            dlo_q   <= dlo_d;
            chk_q   <= chk_d;
            error_q <= error_d;
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes, a monitor pops on write_en.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  word_count = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready, write_en, busy, done, error;
    logic [7:0]  write_address;
    logic [8:0]  instruction;
    logic [15:0] data_var;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [8:0]  instr;
        logic [15:0] data;
    } rec_t;
    rec_t exp_q[$];

    program_loader dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .write_en(write_en), .write_address(write_address), .instruction(instruction),
        .data_var(data_var), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && write_en) begin
            rec_t e;
            wr_cnt++;
            chk("ready_low_in_write", {31'b0, byte_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0h", write_address);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {24'b0, write_address}, {24'b0, e.addr});
                chk("wr_instr", {23'b0, instruction}, {23'b0, e.instr});
                chk("wr_data", {16'b0, data_var}, {16'b0, e.data});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout actual=0 expected=1");
        end
        @(posedge clk);
    endtask

    task automatic stop_bytes();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_record(input logic [7:0] addr, input logic [8:0] instr,
                               input logic [15:0] data, input int gap, input logic bad_chk);
        logic [7:0] b0, b1, b2, b3;
        b0 = instr[7:0];
        b1 = {7'b1010101, instr[8]};
        b2 = data[15:8];
        b3 = data[7:0];
        if (!bad_chk) exp_q.push_back('{addr: addr, instr: instr, data: data});
        send_byte(b0, gap);
        send_byte(b1, gap);
        send_byte(b2, gap);
        send_byte(b3, gap);
`ifdef CHECKSUM_EN
        send_byte(bad_chk ? ~(b0 ^ b1 ^ b2 ^ b3) : (b0 ^ b1 ^ b2 ^ b3), gap);
`endif
    endtask

    task automatic start_load(input logic [7:0] cnt);
        @(negedge clk);
        word_count = cnt;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, {31'b0, done}, 32'd1);
        chk({name, "_busy"}, {31'b0, busy}, 32'd0);
        chk({name, "_pending"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int w0;
        // start coincident with reset release must be ignored
        #12;
        chk("reset_outputs", {byte_ready, write_en, busy, done, error, write_address,
                              instruction, data_var[6:0]}, 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        start      = 1'b1;
        word_count = 8'd1;
        @(negedge clk);
        start = 1'b0;
        chk("start_at_reset_release", {30'b0, busy, byte_ready}, 32'd0);

        // single record, latency and done timing
        start_load(8'd1);
        chk("busy_after_start", {30'b0, busy, byte_ready}, 32'd3);
        send_record(8'h00, 9'h140, 16'h1234, 0, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        chk("write_latency", {31'b0, write_en}, 32'd1);
        @(negedge clk);
        chk("done_after_write", {31'b0, done}, 32'd1);
        wait_done("single");
        chk("outputs_hold", {23'b0, instruction}, 32'h140);

        // three records with gaps between bytes
        start_load(8'd3);
        send_record(8'h00, 9'h0A5, 16'hBEEF, 1, 1'b0);
        send_record(8'h01, 9'h1FF, 16'h0001, 1, 1'b0);
        send_record(8'h02, 9'h100, 16'h8000, 1, 1'b0);
        stop_bytes();
        wait_done("three");

        // count 0 loads 256 records
        w0 = wr_cnt;
        start_load(8'd0);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = 8'(i);
            send_record(a, {a[0], a}, {~a, a}, 0, 1'b0);
        end
        stop_bytes();
        wait_done("full");
        chk("full_count", wr_cnt - w0, 32'd256);
        chk("full_last_addr", {24'b0, write_address}, 32'hFF);

        // reset mid-record discards partial record
        w0 = wr_cnt;
        start_load(8'd1);
        send_byte(8'h77, 0);
        send_byte(8'h01, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {busy, byte_ready, done, error, write_address,
                                    instruction, data_var[11:0]}, 32'd0);
        byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_write_after_reset", wr_cnt - w0, 32'd0);
        start_load(8'd1);
        send_record(8'h00, 9'h033, 16'hCAFE, 0, 1'b0);
        stop_bytes();
        wait_done("after_reset");
        chk("after_reset_count", wr_cnt - w0, 32'd1);

`ifdef CHECKSUM_EN
        w0 = wr_cnt;
        start_load(8'd2);
        send_record(8'h00, 9'h140, 16'h1234, 0, 1'b0);
        send_record(8'h01, 9'h0C3, 16'h5A5A, 0, 1'b1);
        stop_bytes();
        wait_done("chk_abort");
        chk("chk_error", {31'b0, error}, 32'd1);
        chk("chk_one_write", wr_cnt - w0, 32'd1);
        start_load(8'd1);
        chk("chk_cleared", {30'b0, error, done}, 32'd0);
        send_record(8'h00, 9'h001, 16'h0002, 0, 1'b0);
        stop_bytes();
        wait_done("chk_reload");
`else
        chk("error_tied_low", {31'b0, error}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
